// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: next-PC source select, stall/flush, interrupt entry and return-PC capture.
// Optional FETCH_CTRL_NESTED_INT_EN: 2-bit nesting depth counter replaces the single in_service flag.
module fetch_ctrl #(
    parameter int          PC_W         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h20,
    parameter logic [31:0] INT_VECTOR   = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            int_req,
    input  logic            jump_req,
    input  logic            rti_req,
    input  logic            hazard_stall,
    input  logic            imm_flag,
    input  logic [PC_W-1:0] pc_in,
    output logic [1:0]      pc_sel,
    output logic            fetch_stall,
    output logic            flush,
    output logic            int_ack,
    output logic [PC_W-1:0] saved_pc,
    output logic            in_service,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_RUN      = 3'd1,
        S_IMM      = 3'd2,
        S_INT_SAVE = 3'd3,
        S_INT_VEC  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            int_ack_q, int_ack_d;
    logic [PC_W-1:0] saved_pc_q, saved_pc_d;
    logic            accept_ok;
    logic            run_entry;
    logic            entry_done;

    assign run_entry  = int_req && accept_ok && !imm_flag;
    assign entry_done = (state_q == S_INT_VEC);

`ifdef FETCH_CTRL_NESTED_INT_EN
    logic [1:0] depth_q, depth_d;

    // Simultaneous entry and return cancel out, leaving depth unchanged.
    always_comb begin
        depth_d = depth_q;
        if (entry_done && !rti_req) begin
            depth_d = depth_q + 2'd1;
        end else if (rti_req && !entry_done && (depth_q != 2'd0)) begin
            depth_d = depth_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            depth_q <= 2'd0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign accept_ok  = (depth_q != 2'd3);
    assign in_service = (depth_q != 2'd0);
`else
    logic in_service_q, in_service_d;

    always_comb begin
        in_service_d = in_service_q;
        if (entry_done) begin
            in_service_d = 1'b1;
        end else if (rti_req) begin
            in_service_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_service_q <= 1'b0;
        end else begin
            in_service_q <= in_service_d;
        end
    end

    assign accept_ok  = !in_service_q;
    assign in_service = in_service_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            int_ack_q  <= 1'b0;
            saved_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            int_ack_q  <= int_ack_d;
            saved_pc_q <= saved_pc_d;
        end
    end

    // An interrupt held across IMM enters directly on IMM exit, costing one extra cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (jump_req)                        state_d = S_RUN;
                else if (run_entry)                  state_d = S_INT_SAVE;
                else if (imm_flag && !hazard_stall)  state_d = S_IMM;
                else                                 state_d = S_RUN;
            end
            S_IMM: begin
                if (jump_req)                   state_d = S_RUN;
                else if (hazard_stall)          state_d = S_IMM;
                else if (int_req && accept_ok)  state_d = S_INT_SAVE;
                else                            state_d = S_RUN;
            end
            S_INT_SAVE: state_d = S_INT_VEC;
            S_INT_VEC:  state_d = S_RUN;
            default:    state_d = S_BOOT;
        endcase
    end

    assign int_ack_d  = (state_d == S_INT_VEC);
    assign saved_pc_d = (state_q == S_INT_SAVE) ? pc_in : saved_pc_q;

    always_comb begin
        pc_sel      = 2'd0;
        fetch_stall = 1'b0;
        flush       = 1'b0;
        if (!rst) begin
            pc_sel = 2'd2;
            flush  = 1'b1;
        end else begin
            case (state_q)
                S_BOOT: begin
                    pc_sel = 2'd2;
                    flush  = 1'b1;
                end
                S_RUN: begin
                    if (jump_req) begin
                        pc_sel = 2'd1;
                        flush  = 1'b1;
                    end else if (!run_entry && hazard_stall) begin
                        fetch_stall = 1'b1;
                    end
                end
                S_IMM: begin
                    if (jump_req) begin
                        pc_sel = 2'd1;
                        flush  = 1'b1;
                    end else if (hazard_stall) begin
                        fetch_stall = 1'b1;
                    end
                end
                S_INT_SAVE: begin
                    fetch_stall = 1'b1;
                    flush       = 1'b1;
                end
                S_INT_VEC: begin
                    pc_sel = 2'd3;
                    flush  = 1'b1;
                end
                default: begin
                    pc_sel = 2'd2;
                    flush  = 1'b1;
                end
            endcase
        end
    end

    assign int_ack  = int_ack_q && rst;
    assign saved_pc = saved_pc_q;
    assign state    = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (default single-level interrupt build).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        int_req = 1'b0;
    logic        jump_req = 1'b0;
    logic        rti_req = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        imm_flag = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic [1:0]  pc_sel;
    logic        fetch_stall;
    logic        flush;
    logic        int_ack;
    logic [31:0] saved_pc;
    logic        in_service;
    logic [2:0]  state;

    // {state, pc_sel, fetch_stall, flush, int_ack, in_service}
    logic [8:0]  obs;
    logic [8:0]  exp_v;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign obs = {state, pc_sel, fetch_stall, flush, int_ack, in_service};

    always #5 clk = ~clk;

    fetch_ctrl #(.PC_W(32), .RESET_VECTOR(32'h20), .INT_VECTOR(32'h0)) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .jump_req(jump_req),
        .rti_req(rti_req), .hazard_stall(hazard_stall), .imm_flag(imm_flag),
        .pc_in(pc_in), .pc_sel(pc_sel), .fetch_stall(fetch_stall), .flush(flush),
        .int_ack(int_ack), .saved_pc(saved_pc), .in_service(in_service), .state(state)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(); tick(); tick();
        #1;
        exp_v = {3'd0, 2'd2, 4'b0100};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL reset_low: obs=%b expected=%b", obs, exp_v); end
        n_cmp++; if (saved_pc !== 32'h0) begin n_bad++; $display("FAIL reset_saved_pc: got %h expected %h", saved_pc, 32'h0); end
        rst = 1'b1;
        #1;
        exp_v = {3'd0, 2'd2, 4'b0100};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL boot_cycle: obs=%b expected=%b", obs, exp_v); end
        tick();
        exp_v = {3'd1, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL run_after_boot: obs=%b expected=%b", obs, exp_v); end
        $display("reset: obs=%b", obs);
    endtask

    task automatic test_hazard;
        hazard_stall = 1'b1;
        #1;
        exp_v = {3'd1, 2'd0, 4'b1000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL run_stall: obs=%b expected=%b", obs, exp_v); end
        imm_flag = 1'b1;
        tick();
        exp_v = {3'd1, 2'd0, 4'b1000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL imm_stalled_in_run: obs=%b expected=%b", obs, exp_v); end
        hazard_stall = 1'b0;
        tick();
        imm_flag = 1'b0;
        #1;
        exp_v = {3'd2, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL imm_state: obs=%b expected=%b", obs, exp_v); end
        tick();
        exp_v = {3'd1, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL imm_exit: obs=%b expected=%b", obs, exp_v); end
        $display("hazard/imm: obs=%b", obs);
    endtask

    task automatic test_int_entry;
        pc_in = 32'h40; int_req = 1'b1;
        #1;
        exp_v = {3'd1, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL int_req_run: obs=%b expected=%b", obs, exp_v); end
        tick();
        jump_req = 1'b1; hazard_stall = 1'b1;
        #1;
        exp_v = {3'd3, 2'd0, 4'b1100};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL int_save: obs=%b expected=%b", obs, exp_v); end
        tick();
        jump_req = 1'b0; hazard_stall = 1'b0;
        #1;
        exp_v = {3'd4, 2'd3, 4'b0110};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL int_vec: obs=%b expected=%b", obs, exp_v); end
        n_cmp++; if (saved_pc !== 32'h40) begin n_bad++; $display("FAIL saved_pc_40: got %h expected %h", saved_pc, 32'h40); end
        int_req = 1'b0; rti_req = 1'b1;
        tick();
        rti_req = 1'b0;
        #1;
        exp_v = {3'd1, 2'd0, 4'b0001};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL entry_beats_rti: obs=%b expected=%b", obs, exp_v); end
        $display("int entry: saved_pc=%h obs=%b", saved_pc, obs);
    endtask

    task automatic test_masked_rti;
        int_req = 1'b1; pc_in = 32'h60;
        tick();
        exp_v = {3'd1, 2'd0, 4'b0001};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL masked_no_entry: obs=%b expected=%b", obs, exp_v); end
        rti_req = 1'b1;
        tick();
        rti_req = 1'b0;
        #1;
        exp_v = {3'd1, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL rti_clears: obs=%b expected=%b", obs, exp_v); end
        tick();
        exp_v = {3'd3, 2'd0, 4'b1100};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL post_rti_save: obs=%b expected=%b", obs, exp_v); end
        tick();
        exp_v = {3'd4, 2'd3, 4'b0110};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL post_rti_vec: obs=%b expected=%b", obs, exp_v); end
        n_cmp++; if (saved_pc !== 32'h60) begin n_bad++; $display("FAIL saved_pc_60: got %h expected %h", saved_pc, 32'h60); end
        int_req = 1'b0;
        tick();
        rti_req = 1'b1;
        tick();
        rti_req = 1'b0;
        #1;
        exp_v = {3'd1, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL rti_idle: obs=%b expected=%b", obs, exp_v); end
        $display("masked/rti: saved_pc=%h obs=%b", saved_pc, obs);
    endtask

    task automatic test_imm_defer;
        pc_in = 32'h50; imm_flag = 1'b1; int_req = 1'b1;
        #1;
        exp_v = {3'd1, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL imm_int_run: obs=%b expected=%b", obs, exp_v); end
        tick();
        imm_flag = 1'b0; pc_in = 32'h54; hazard_stall = 1'b1;
        #1;
        exp_v = {3'd2, 2'd0, 4'b1000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL imm_stall: obs=%b expected=%b", obs, exp_v); end
        tick();
        hazard_stall = 1'b0;
        #1;
        exp_v = {3'd2, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL imm_deferred: obs=%b expected=%b", obs, exp_v); end
        tick();
        pc_in = 32'h58;
        #1;
        exp_v = {3'd3, 2'd0, 4'b1100};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL imm_then_save: obs=%b expected=%b", obs, exp_v); end
        tick();
        exp_v = {3'd4, 2'd3, 4'b0110};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL imm_then_vec: obs=%b expected=%b", obs, exp_v); end
        n_cmp++; if (saved_pc !== 32'h58) begin n_bad++; $display("FAIL saved_pc_58: got %h expected %h", saved_pc, 32'h58); end
        int_req = 1'b0;
        tick();
        rti_req = 1'b1;
        tick();
        rti_req = 1'b0;
        $display("imm defer: saved_pc=%h obs=%b", saved_pc, obs);
    endtask

    task automatic test_jump_reset_abort;
        pc_in = 32'h70; jump_req = 1'b1; int_req = 1'b1;
        #1;
        exp_v = {3'd1, 2'd1, 4'b0100};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL jump_over_int: obs=%b expected=%b", obs, exp_v); end
        tick();
        jump_req = 1'b0; pc_in = 32'h90;
        #1;
        exp_v = {3'd1, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL jump_stays_run: obs=%b expected=%b", obs, exp_v); end
        tick();
        rst = 1'b0;
        #1;
        exp_v = {3'd3, 2'd2, 4'b0100};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL rst_in_save: obs=%b expected=%b", obs, exp_v); end
        tick();
        exp_v = {3'd0, 2'd2, 4'b0100};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL abort_to_boot: obs=%b expected=%b", obs, exp_v); end
        n_cmp++; if (saved_pc !== 32'h0) begin n_bad++; $display("FAIL abort_saved_pc: got %h expected %h", saved_pc, 32'h0); end
        tick();
        n_cmp++; if (int_ack !== 1'b0) begin n_bad++; $display("FAIL abort_no_ack: got %b expected %b", int_ack, 1'b0); end
        int_req = 1'b0; rst = 1'b1;
        tick();
        exp_v = {3'd1, 2'd0, 4'b0000};
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL rerun_after_abort: obs=%b expected=%b", obs, exp_v); end
        $display("jump/reset abort: obs=%b", obs);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hazard();
        test_int_entry();
        test_masked_rti();
        test_imm_defer();
        test_jump_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
